otp_ctrl_lci_rsp: RTL and testbench
===================================

// Module: otp_ctrl_lci_rsp
// PURPOSE
// - Responder end of the OTP native command interface used by the life cycle write interface.
// - Models the OTP word array behind the LC partition:
//   - accepts one Read/Write/Init command at a time;
//   - grants it, waits a fixed latency, then returns rvalid with rdata/err;
//   - enforces write-once bit semantics.
// - Used as the OTP back end in LC-transition subsystem benches and in FPGA builds without a macro.
// PARAMETERS
// - NumWords    44    number of 16-bit OTP words in the partition (88-byte LC partition)
// - BaseAddr    0     halfword address of word 0; commands outside [BaseAddr, BaseAddr+NumWords) fail
// - RspLatency  2     cycles from grant to rvalid, range 1..15
// - GntDelay    0     cycles req must be held before gnt, range 0..7
// PORTS
// - clk_i         in   1                  clock
// - rst_ni        in   1                  async active-low reset
// - otp_req_i     in   1                  command request, held until gnt
// - otp_cmd_i     in   prim_otp_pkg::cmd_e  Read / Write / Init
// - otp_size_i    in   OtpSizeWidth       number of 16-bit words minus 1 (0..3)
// - otp_wdata_i   in   OtpIfWidth         write data; word k at bits [16k+15:16k]
// - otp_addr_i    in   OtpAddrWidth       halfword address of first word
// - otp_gnt_o     out  1                  1-cycle command accept
// - otp_rvalid_o  out  1                  1-cycle response strobe
// - otp_rdata_o   out  ScrmblBlockWidth   read data, zero-extended; 0 for Write/Init
// - otp_err_o     out  prim_otp_pkg::err_e  response code, valid with rvalid, NoError otherwise
// - err_inj_i     in   1                  sampled at gnt; forces MacroError on that command, no storage update
// - busy_o        out  1                  high from gnt through the rvalid cycle
// BEHAVIOUR
// - Reset values:
//   - storage all-zero (blank);
//   - all outputs 0 / NoError;
//   - FSM in IdleSt;
//   - gnt/delay counters 0.
// - FSM states (sparse, min Hamming distance 5): IdleSt, GntWaitSt, BusySt, RspSt, ErrorSt.
// - IdleSt: on req_i:
//   - GntDelay==0: gnt=1 in the same cycle; latch cmd/addr/size/wdata/err_inj; go to BusySt.
//   - GntDelay>0: go to GntWaitSt.
// - GntWaitSt: count GntDelay cycles with req_i held, then gnt and latch as above.
//   - If req_i drops early: return to IdleSt, counter cleared, no gnt.
// - BusySt: latency counter runs RspLatency-1 cycles, then go to RspSt.
//   - gnt-to-rvalid distance is exactly RspLatency cycles.
// - RspSt: rvalid=1 with rdata/err for one cycle, storage update in the same edge, go to IdleSt.
//   - A new req may be granted no earlier than the cycle after rvalid, so there is only one outstanding command.
// - Address check:
//   - last = addr+size; fail if addr<BaseAddr or last>=BaseAddr+NumWords.
//   - Arithmetic is in OtpAddrWidth+1 bits, so wrap-around at the top of the address space is caught.
//   - Failure gives MacroError and no update.
// - Write, per word k: blank violation if (mem & ~wdata_k) != 0, i.e. the write would clear a programmed bit.
//   - Any violation: MacroWriteBlankError, no word in the command is updated.
//   - Otherwise: mem <= mem | wdata_k for all words.
// - Read: rdata[16k+:16] = mem[addr-BaseAddr+k] for k<=size; upper bits 0; err NoError.
// - Init: NoError, no side effect. Any undefined cmd encoding: MacroError.
// - Error priority: err_inj > address/cmd > blank.
// - Illegal FSM state:
//   - go to ErrorSt (terminal until reset);
//   - in ErrorSt: gnt still given, every response is MacroError, storage frozen.
// - Reset mid-command: the command is dropped, no rvalid, storage returns to blank.
// - Counter values are checked against the state; a mismatch forces ErrorSt.
// STRUCTURE
// - Shared package otp_ctrl_lci_rsp_pkg:
//   - state_e encoding;
//   - NumWords/RspLatency width constants;
//   - function blank_check(mem, wdata) -> bit.
// - One sub-module otp_ctrl_lci_rsp_mem:
//   - NumWords x 16 flop array;
//   - 4-word read port and OR-merge write port;
//   - write enable gated by the FSM.
// - FSM, counters and address check stay in the top.
// TESTING
// - Reset, then Write addr=BaseAddr, wdata=16'hA5A5 -> gnt at cycle 0, rvalid at cycle 2, err NoError; Read -> rdata=64'h000000000000A5A5.
// - Write 16'h00FF, then 16'h0F0F to the same word -> MacroWriteBlankError, word stays 16'h00FF; then Write 16'hFFFF -> NoError, word 16'hFFFF.
// - Read size=3 at BaseAddr+NumWords-2 -> MacroError, rdata=0; Read size=1 at the same address -> NoError.
// - 44 back-to-back single-word writes with data i+1, then read all words -> each returns i+1; rvalid never overlaps a second gnt.
// - GntDelay=3, req dropped after 2 cycles -> no gnt and no rvalid; req held 3 cycles -> gnt, rvalid RspLatency cycles later.
// - Assert rst_ni during BusySt after a Write -> no rvalid, busy_o=0; subsequent Read returns 0.

Source files
------------

// File: rtl/otp_ctrl_lci_rsp_pkg.sv
// Shared types and constants for the OTP LC-partition responder model.
package otp_ctrl_lci_rsp_pkg;

    localparam int OtpWordWidth     = 16;
    localparam int OtpIfWords       = 4;
    localparam int OtpIfWidth       = OtpIfWords * OtpWordWidth;
    localparam int OtpSizeWidth     = 2;
    localparam int OtpAddrWidth     = 11;
    localparam int ScrmblBlockWidth = 64;

    // One extra bit so addr+size cannot silently wrap at the top of the space.
    localparam int IdxWidth = OtpAddrWidth + 1;

    // Latency (1..15) and grant-delay (0..7) down-counter widths.
    localparam int LatCntWidth = 4;
    localparam int GntCntWidth = 3;

    localparam int NumWordsDefault = 44;

    // Index width into the word array; never below 1 bit.
    function automatic int mem_idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    localparam int NumWordsIdxWidth = mem_idx_width(NumWordsDefault);

    typedef enum logic [1:0] {
        Read  = 2'b00,
        Write = 2'b01,
        Init  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        NoError              = 3'h0,
        MacroError           = 3'h1,
        MacroEccCorrError    = 3'h2,
        MacroEccUncorrError  = 3'h3,
        MacroWriteBlankError = 3'h4
    } err_e;

    // Pairwise Hamming distance >= 6; the all-zero code is the error state.
    typedef enum logic [11:0] {
        IdleSt    = 12'b111000_000111,
        GntWaitSt = 12'b000000_111111,
        BusySt    = 12'b111111_000000,
        RspSt     = 12'b111111_111111,
        ErrorSt   = 12'b000000_000000
    } state_e;

    // Returns 1 when writing wdata would have to clear an already programmed bit.
    function automatic logic blank_check(input logic [OtpWordWidth-1:0] mem,
                                         input logic [OtpWordWidth-1:0] wdata);
        return |(mem & ~wdata);
    endfunction

endpackage

// File: rtl/otp_ctrl_lci_rsp_mem.sv
// OTP word array: NumWords x 16 flops, 4-word read port, OR-merge write port.
module otp_ctrl_lci_rsp_mem
    import otp_ctrl_lci_rsp_pkg::*;
#(
    parameter int NumWords = 44
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [IdxWidth-1:0]     rd_idx_i,
    output logic [OtpIfWidth-1:0]   rd_data_o,
    input  logic                    wr_en_i,
    input  logic [IdxWidth-1:0]     wr_idx_i,
    input  logic [OtpSizeWidth-1:0] wr_size_i,
    input  logic [OtpIfWidth-1:0]   wr_data_i
);

    localparam int MemIdxWidth = mem_idx_width(NumWords);
    localparam logic [IdxWidth-1:0] NumWordsExt = IdxWidth'(NumWords);

    logic [OtpWordWidth-1:0] mem_q [NumWords];

    logic [MemIdxWidth-1:0] rd_pos [OtpIfWords];
    logic                   rd_hit [OtpIfWords];
    logic [MemIdxWidth-1:0] wr_pos [OtpIfWords];
    logic                   wr_hit [OtpIfWords];

    // Per-lane word positions; lanes past the array end read 0 and never write.
    always_comb begin
        for (int k = 0; k < OtpIfWords; k++) begin
            rd_pos[k] = MemIdxWidth'(rd_idx_i + IdxWidth'(k));
            rd_hit[k] = (rd_idx_i + IdxWidth'(k)) < NumWordsExt;
            wr_pos[k] = MemIdxWidth'(wr_idx_i + IdxWidth'(k));
            wr_hit[k] = ((wr_idx_i + IdxWidth'(k)) < NumWordsExt) &&
                        (OtpSizeWidth'(k) <= wr_size_i);
        end
    end

    // Read port assembly.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < OtpIfWords; k++) begin
            if (rd_hit[k]) begin
                rd_data_o[OtpWordWidth*k +: OtpWordWidth] = mem_q[rd_pos[k]];
            end
        end
    end

    // Storage: blank at reset, bits only ever get set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else if (wr_en_i) begin
            for (int k = 0; k < OtpIfWords; k++) begin
                if (wr_hit[k]) begin
                    mem_q[wr_pos[k]] <= mem_q[wr_pos[k]] |
                                        wr_data_i[OtpWordWidth*k +: OtpWordWidth];
                end
            end
        end
    end

endmodule

// File: rtl/otp_ctrl_lci_rsp.sv
// OTP native-interface responder modelling the LC partition word array.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IdleSt    | no command; grants immediately when GntDelay is 0
// GntWaitSt | req seen, counting down the grant delay
// BusySt    | command accepted, counting down the response latency
// RspSt     | rvalid cycle; storage updated on the exiting edge
// ErrorSt   | terminal; still grants, always answers MacroError
module otp_ctrl_lci_rsp
    import otp_ctrl_lci_rsp_pkg::*;
#(
    parameter int NumWords   = 44,
    parameter int BaseAddr   = 0,
    parameter int RspLatency = 2,
    parameter int GntDelay   = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        otp_req_i,
    input  cmd_e                        otp_cmd_i,
    input  logic [OtpSizeWidth-1:0]     otp_size_i,
    input  logic [OtpIfWidth-1:0]       otp_wdata_i,
    input  logic [OtpAddrWidth-1:0]     otp_addr_i,
    output logic                        otp_gnt_o,
    output logic                        otp_rvalid_o,
    output logic [ScrmblBlockWidth-1:0] otp_rdata_o,
    output err_e                        otp_err_o,
    input  logic                        err_inj_i,
    output logic                        busy_o
);

    localparam logic [IdxWidth-1:0]    BaseExt = IdxWidth'(BaseAddr);
    localparam logic [IdxWidth-1:0]    EndExt  = IdxWidth'(BaseAddr + NumWords);
    localparam logic [LatCntWidth-1:0] LatLoad = LatCntWidth'(RspLatency - 1);
    localparam logic [GntCntWidth-1:0] GntLoad = GntCntWidth'((GntDelay > 0) ? GntDelay - 1 : 0);

    state_e                        state_q;
    logic [LatCntWidth-1:0]        lat_cnt_q;
    logic [GntCntWidth-1:0]        gnt_cnt_q;
    err_e                          rsp_err_q;
    logic [ScrmblBlockWidth-1:0]   rsp_rdata_q;
    logic                          rsp_we_q;
    logic [IdxWidth-1:0]           wr_idx_q;
    logic [OtpSizeWidth-1:0]       wr_size_q;
    logic [OtpIfWidth-1:0]         wr_data_q;
    logic                          err_busy_q;
    logic                          err_rsp_q;

    logic [IdxWidth-1:0]           addr_ext;
    logic [IdxWidth-1:0]           last_ext;
    logic [IdxWidth-1:0]           rd_idx;
    logic                          addr_ok;
    logic                          cmd_ok;
    logic                          blank_viol;
    logic [OtpIfWidth-1:0]         rd_data;
    err_e                          rsp_err_d;
    logic [ScrmblBlockWidth-1:0]   rsp_rdata_d;
    logic                          cnt_err;

    otp_ctrl_lci_rsp_mem #(
        .NumWords (NumWords)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .wr_en_i   (state_q == RspSt && rsp_we_q),
        .wr_idx_i  (wr_idx_q),
        .wr_size_i (wr_size_q),
        .wr_data_i (wr_data_q)
    );

    // Range check on the incoming command, done in one extra bit.
    always_comb begin
        addr_ext = {1'b0, otp_addr_i};
        last_ext = addr_ext + IdxWidth'(otp_size_i);
        rd_idx   = addr_ext - BaseExt;
        addr_ok  = (addr_ext >= BaseExt) && (last_ext < EndExt);
        cmd_ok   = otp_cmd_i inside {Read, Write, Init};
    end

    // Response is resolved at grant time; storage cannot change before the
    // response because only one command is ever outstanding.
    always_comb begin
        blank_viol  = 1'b0;
        rsp_rdata_d = '0;
        for (int k = 0; k < OtpIfWords; k++) begin
            if (OtpSizeWidth'(k) <= otp_size_i) begin
                if (blank_check(rd_data[OtpWordWidth*k +: OtpWordWidth],
                                otp_wdata_i[OtpWordWidth*k +: OtpWordWidth])) begin
                    blank_viol = 1'b1;
                end
                rsp_rdata_d[OtpWordWidth*k +: OtpWordWidth] =
                    rd_data[OtpWordWidth*k +: OtpWordWidth];
            end
        end
        if (err_inj_i || !cmd_ok || !addr_ok) begin
            rsp_err_d = MacroError;
        end else if (otp_cmd_i == Write && blank_viol) begin
            rsp_err_d = MacroWriteBlankError;
        end else begin
            rsp_err_d = NoError;
        end
        if (rsp_err_d != NoError || otp_cmd_i != Read) begin
            rsp_rdata_d = '0;
        end
    end

    // Counters must be consistent with the state they belong to.
    always_comb begin
        case (state_q)
            IdleSt:    cnt_err = (lat_cnt_q != '0) || (gnt_cnt_q != '0);
            GntWaitSt: cnt_err = (lat_cnt_q != '0) || (gnt_cnt_q > GntLoad);
            BusySt:    cnt_err = (lat_cnt_q == '0) || (lat_cnt_q > LatLoad) ||
                                 (gnt_cnt_q != '0);
            RspSt:     cnt_err = (lat_cnt_q != '0) || (gnt_cnt_q != '0);
            ErrorSt:   cnt_err = 1'b0;
            default:   cnt_err = 1'b1;
        endcase
    end

    // Grant, response strobe and busy decode.
    always_comb begin
        otp_gnt_o = 1'b0;
        if (otp_req_i && !cnt_err) begin
            case (state_q)
                IdleSt:    otp_gnt_o = (GntDelay == 0);
                GntWaitSt: otp_gnt_o = (gnt_cnt_q == '0);
                ErrorSt:   otp_gnt_o = !err_busy_q && !err_rsp_q;
                default:   otp_gnt_o = 1'b0;
            endcase
        end
        otp_rvalid_o = (state_q == RspSt) || (state_q == ErrorSt && err_rsp_q);
        otp_rdata_o  = (state_q == RspSt) ? rsp_rdata_q : '0;
        if (state_q == RspSt) begin
            otp_err_o = rsp_err_q;
        end else if (state_q == ErrorSt && err_rsp_q) begin
            otp_err_o = MacroError;
        end else begin
            otp_err_o = NoError;
        end
        busy_o = (state_q == BusySt) || (state_q == RspSt) ||
                 (state_q == ErrorSt && (err_busy_q || err_rsp_q));
    end

    // Command sequencing FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IdleSt;
            lat_cnt_q   <= '0;
            gnt_cnt_q   <= '0;
            rsp_err_q   <= NoError;
            rsp_rdata_q <= '0;
            rsp_we_q    <= 1'b0;
            wr_idx_q    <= '0;
            wr_size_q   <= '0;
            wr_data_q   <= '0;
            err_busy_q  <= 1'b0;
            err_rsp_q   <= 1'b0;
        end else if (cnt_err) begin
            state_q    <= ErrorSt;
            lat_cnt_q  <= '0;
            gnt_cnt_q  <= '0;
            rsp_we_q   <= 1'b0;
            err_busy_q <= 1'b0;
            err_rsp_q  <= 1'b0;
        end else begin
            if (otp_gnt_o && state_q != ErrorSt) begin
                wr_idx_q    <= rd_idx;
                wr_size_q   <= otp_size_i;
                wr_data_q   <= otp_wdata_i;
                rsp_err_q   <= rsp_err_d;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_we_q    <= (rsp_err_d == NoError) && (otp_cmd_i == Write);
                gnt_cnt_q   <= '0;
                if (RspLatency == 1) begin
                    state_q <= RspSt;
                end else begin
                    state_q   <= BusySt;
                    lat_cnt_q <= LatLoad;
                end
            end else begin
                case (state_q)
                    IdleSt: begin
                        if (otp_req_i) begin
                            state_q   <= GntWaitSt;
                            gnt_cnt_q <= GntLoad;
                        end
                    end
                    GntWaitSt: begin
                        if (!otp_req_i) begin
                            state_q   <= IdleSt;
                            gnt_cnt_q <= '0;
                        end else begin
                            gnt_cnt_q <= gnt_cnt_q - GntCntWidth'(1);
                        end
                    end
                    BusySt: begin
                        if (lat_cnt_q == LatCntWidth'(1)) begin
                            state_q   <= RspSt;
                            lat_cnt_q <= '0;
                        end else begin
                            lat_cnt_q <= lat_cnt_q - LatCntWidth'(1);
                        end
                    end
                    RspSt: begin
                        state_q  <= IdleSt;
                        rsp_we_q <= 1'b0;
                    end
                    ErrorSt: begin
                        if (err_rsp_q) begin
                            err_rsp_q <= 1'b0;
                        end else if (err_busy_q) begin
                            if (lat_cnt_q <= LatCntWidth'(1)) begin
                                err_busy_q <= 1'b0;
                                err_rsp_q  <= 1'b1;
                                lat_cnt_q  <= '0;
                            end else begin
                                lat_cnt_q <= lat_cnt_q - LatCntWidth'(1);
                            end
                        end else if (otp_gnt_o) begin
                            if (RspLatency == 1) begin
                                err_rsp_q <= 1'b1;
                            end else begin
                                err_busy_q <= 1'b1;
                                lat_cnt_q  <= LatLoad;
                            end
                        end
                    end
                    default: state_q <= ErrorSt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_otp_ctrl_lci_rsp.sv
// Directed bench for otp_ctrl_lci_rsp: default instance plus a GntDelay=3 instance.
module tb_otp_ctrl_lci_rsp;
    import otp_ctrl_lci_rsp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    cmd_e        cmd = Read;
    logic [1:0]  size = '0;
    logic [63:0] wdata = '0;
    logic [10:0] addr = '0;
    logic        err_inj = 1'b0;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy0, busy1;
    logic [63:0] rdata0, rdata1;
    err_e        err0, err1;

    int checks = 0;
    int errors = 0;
    int overlap0 = 0;

    always #5 clk = ~clk;

    otp_ctrl_lci_rsp dut (
        .clk_i(clk), .rst_ni(rst_ni), .otp_req_i(req0), .otp_cmd_i(cmd),
        .otp_size_i(size), .otp_wdata_i(wdata), .otp_addr_i(addr),
        .otp_gnt_o(gnt0), .otp_rvalid_o(rvalid0), .otp_rdata_o(rdata0),
        .otp_err_o(err0), .err_inj_i(err_inj), .busy_o(busy0)
    );

    otp_ctrl_lci_rsp #(.GntDelay(3)) dut_d (
        .clk_i(clk), .rst_ni(rst_ni), .otp_req_i(req1), .otp_cmd_i(cmd),
        .otp_size_i(size), .otp_wdata_i(wdata), .otp_addr_i(addr),
        .otp_gnt_o(gnt1), .otp_rvalid_o(rvalid1), .otp_rdata_o(rdata1),
        .otp_err_o(err1), .err_inj_i(err_inj), .busy_o(busy1)
    );

    always @(negedge clk) if (gnt0 && rvalid0) overlap0 <= overlap0 + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Issue one command; cycle 0 is the cycle req is first driven. -1 means never seen.
    task automatic do_cmd(input bit which, input cmd_e c, input logic [10:0] a,
                          input logic [1:0] s, input logic [63:0] wd, input logic inj,
                          output int gnt_cyc, output int rsp_cyc,
                          output logic [63:0] rd, output err_e e);
        gnt_cyc = -1; rsp_cyc = -1; rd = '0; e = NoError;
        cmd = c; addr = a; size = s; wdata = wd; err_inj = inj;
        if (which) req1 = 1'b1; else req0 = 1'b1;
        for (int i = 0; i < 40 && rsp_cyc < 0; i++) begin
            @(negedge clk);
            if ((which ? gnt1 : gnt0) && gnt_cyc < 0) gnt_cyc = i;
            if (which ? rvalid1 : rvalid0) begin
                rsp_cyc = i;
                rd = which ? rdata1 : rdata0;
                e  = which ? err1 : err0;
            end
            @(posedge clk); #1;
            if (gnt_cyc >= 0) begin req0 = 1'b0; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0; err_inj = 1'b0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt0); end
        checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid0); end
        checks++; if (rdata0 !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata0); end
        checks++; if (err0 !== NoError) begin errors++; $display("FAIL reset_err got %0d want 0", err0); end
        checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b want 00", busy0, busy1); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int g, r; logic [63:0] d; err_e e;
        do_cmd(0, Write, 11'd0, 2'd0, 64'hA5A5, 1'b0, g, r, d, e);
        checks++; if (g !== 0) begin errors++; $display("FAIL wr_gnt_cycle got %0d want 0", g); end
        checks++; if (r !== 2) begin errors++; $display("FAIL wr_rvalid_cycle got %0d want 2", r); end
        checks++; if (e !== NoError) begin errors++; $display("FAIL wr_err got %0d want 0", e); end
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", d); end
        do_cmd(0, Read, 11'd0, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (r !== 2) begin errors++; $display("FAIL rd_rvalid_cycle got %0d want 2", r); end
        checks++; if (d !== 64'h000000000000A5A5) begin errors++; $display("FAIL rd_data got %h want a5a5", d); end
        checks++; if (e !== NoError) begin errors++; $display("FAIL rd_err got %0d want 0", e); end
    endtask

    task automatic test_blank();
        int g, r; logic [63:0] d; err_e e;
        do_cmd(0, Write, 11'd1, 2'd0, 64'h00FF, 1'b0, g, r, d, e);
        checks++; if (e !== NoError) begin errors++; $display("FAIL blank_first_err got %0d want 0", e); end
        do_cmd(0, Write, 11'd1, 2'd0, 64'h0F0F, 1'b0, g, r, d, e);
        checks++; if (e !== MacroWriteBlankError) begin errors++; $display("FAIL blank_viol_err got %0d want 4", e); end
        do_cmd(0, Read, 11'd1, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (d !== 64'h00FF) begin errors++; $display("FAIL blank_keep got %h want 00ff", d); end
        do_cmd(0, Write, 11'd1, 2'd0, 64'hFFFF, 1'b0, g, r, d, e);
        checks++; if (e !== NoError) begin errors++; $display("FAIL blank_superset_err got %0d want 0", e); end
        do_cmd(0, Read, 11'd1, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (d !== 64'hFFFF) begin errors++; $display("FAIL blank_superset_data got %h want ffff", d); end
        // Word 1 would be cleared, so word 2 must not be written either.
        do_cmd(0, Write, 11'd1, 2'd1, 64'h0000_0000_1234_0000, 1'b0, g, r, d, e);
        checks++; if (e !== MacroWriteBlankError) begin errors++; $display("FAIL blank_multi_err got %0d want 4", e); end
        do_cmd(0, Read, 11'd1, 2'd1, 64'h0, 1'b0, g, r, d, e);
        checks++; if (d !== 64'h0000_0000_0000_FFFF) begin errors++; $display("FAIL blank_multi_data got %h want ffff", d); end
    endtask

    task automatic test_addr_cmd();
        int g, r; logic [63:0] d; err_e e;
        do_cmd(0, Write, 11'd43, 2'd0, 64'hC3C3, 1'b0, g, r, d, e);
        checks++; if (e !== NoError) begin errors++; $display("FAIL last_word_wr got %0d want 0", e); end
        do_cmd(0, Read, 11'd42, 2'd3, 64'h0, 1'b0, g, r, d, e);
        checks++; if (e !== MacroError) begin errors++; $display("FAIL oob_err got %0d want 1", e); end
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL oob_rdata got %h want 0", d); end
        do_cmd(0, Read, 11'd42, 2'd1, 64'h0, 1'b0, g, r, d, e);
        checks++; if (e !== NoError) begin errors++; $display("FAIL edge_err got %0d want 0", e); end
        checks++; if (d !== 64'h0000_0000_C3C3_0000) begin errors++; $display("FAIL edge_rdata got %h want c3c30000", d); end
        do_cmd(0, Read, 11'd40, 2'd3, 64'h0, 1'b0, g, r, d, e);
        checks++; if (d !== 64'hC3C3_0000_0000_0000) begin errors++; $display("FAIL four_word_rdata got %h want c3c3000000000000", d); end
        do_cmd(0, Read, 11'd2046, 2'd3, 64'h0, 1'b0, g, r, d, e);
        checks++; if (e !== MacroError) begin errors++; $display("FAIL top_addr_err got %0d want 1", e); end
        do_cmd(0, cmd_e'(2'b10), 11'd0, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (e !== MacroError) begin errors++; $display("FAIL bad_cmd_err got %0d want 1", e); end
        do_cmd(0, Write, 11'd3, 2'd0, 64'h1111, 1'b1, g, r, d, e);
        checks++; if (e !== MacroError) begin errors++; $display("FAIL inj_err got %0d want 1", e); end
        do_cmd(0, Read, 11'd3, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL inj_no_update got %h want 0", d); end
        do_cmd(0, Init, 11'd0, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (e !== NoError || d !== 64'h0) begin errors++; $display("FAIL init got err %0d data %h want 0 0", e, d); end
    endtask

    task automatic test_back_to_back();
        int g, r; logic [63:0] d; err_e e;
        apply_reset();
        overlap0 = 0;
        for (int i = 0; i < 44; i++) begin
            do_cmd(0, Write, 11'(i), 2'd0, 64'(i + 1), 1'b0, g, r, d, e);
            checks++;
            if (g !== 0 || r !== 2 || e !== NoError) begin
                errors++; $display("FAIL b2b_wr[%0d] got gnt %0d rsp %0d err %0d want 0 2 0", i, g, r, e);
            end
        end
        for (int i = 0; i < 44; i++) begin
            do_cmd(0, Read, 11'(i), 2'd0, 64'h0, 1'b0, g, r, d, e);
            checks++;
            if (d !== 64'(i + 1)) begin errors++; $display("FAIL b2b_rd[%0d] got %h want %h", i, d, 64'(i + 1)); end
        end
        checks++; if (overlap0 !== 0) begin errors++; $display("FAIL b2b_overlap got %0d want 0", overlap0); end
    endtask

    task automatic test_gnt_delay();
        int g, r; logic [63:0] d; err_e e;
        int seen_gnt, seen_rv;
        seen_gnt = 0; seen_rv = 0;
        cmd = Write; addr = 11'd7; size = 2'd0; wdata = 64'h7777;
        req1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (gnt1) seen_gnt++;
            @(posedge clk); #1;
        end
        req1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gnt1) seen_gnt++;
            if (rvalid1 || busy1) seen_rv++;
            @(posedge clk); #1;
        end
        checks++; if (seen_gnt !== 0) begin errors++; $display("FAIL drop_gnt got %0d want 0", seen_gnt); end
        checks++; if (seen_rv !== 0) begin errors++; $display("FAIL drop_rvalid got %0d want 0", seen_rv); end
        do_cmd(1, Write, 11'd0, 2'd0, 64'h5A5A, 1'b0, g, r, d, e);
        checks++; if (g !== 3) begin errors++; $display("FAIL delay_gnt_cycle got %0d want 3", g); end
        checks++; if (r !== 5) begin errors++; $display("FAIL delay_rvalid_cycle got %0d want 5", r); end
        do_cmd(1, Read, 11'd7, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL drop_no_write got %h want 0", d); end
        do_cmd(1, Read, 11'd0, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (d !== 64'h5A5A) begin errors++; $display("FAIL delay_rd got %h want 5a5a", d); end
    endtask

    task automatic test_reset_mid();
        int g, r; logic [63:0] d; err_e e;
        int seen_rv;
        seen_rv = 0;
        cmd = Write; addr = 11'd5; size = 2'd0; wdata = 64'hBEEF; req0 = 1'b1;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b want 1", gnt0); end
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy0); end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (busy0 !== 1'b0 || rvalid0 !== 1'b0) begin errors++; $display("FAIL mid_rst_out got busy %b rvalid %b want 0 0", busy0, rvalid0); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rvalid0) seen_rv++;
        end
        @(posedge clk); #1 rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (rvalid0) seen_rv++;
        end
        @(posedge clk); #1;
        checks++; if (seen_rv !== 0) begin errors++; $display("FAIL mid_rvalid got %0d want 0", seen_rv); end
        do_cmd(0, Read, 11'd5, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (d !== 64'h0 || e !== NoError) begin errors++; $display("FAIL mid_read got %h err %0d want 0 0", d, e); end
        do_cmd(0, Read, 11'd0, 2'd0, 64'h0, 1'b0, g, r, d, e);
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL mid_blank got %h want 0", d); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        test_reset();
        test_write_read();
        test_blank();
        test_addr_cmd();
        test_back_to_back();
        test_gnt_delay();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
